// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM burst controller.
package sram_pkg;

    localparam int DEF_A_WIDTH     = 23;
    localparam int DEF_D_WIDTH     = 16;
    localparam int DEF_L_WIDTH     = 4;
    localparam int DEF_WAIT_CYCLES = 2;

    // SRAM strobes are active-low.
    localparam logic STROBE_OFF = 1'b1;
    localparam logic STROBE_ON  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WAIT  = 3'd2,
        ST_XFER  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Round-robin winner index for two requesters; on a tie the one not
    // served last wins. Result is meaningless when nobody is requesting.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Bus-side requester signals and SRAM pin group for the burst controller.
interface sram_burst_ctrl_if
    import sram_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int L_WIDTH = DEF_L_WIDTH
);
    logic [1:0]           req;
    logic [1:0]           req_we;
    logic [2*A_WIDTH-1:0] req_addr;
    logic [2*L_WIDTH-1:0] req_len;
    logic [2*D_WIDTH-1:0] req_wdata;
    logic [1:0]           gnt;
    logic [1:0]           beat;
    logic [1:0]           done;
    logic [D_WIDTH-1:0]   rdata;
    logic [A_WIDTH-1:0]   mem_addr;
    logic [D_WIDTH-1:0]   mem_dq_out;
    logic                 mem_dq_oe;
    logic [D_WIDTH-1:0]   mem_dq_in;
    logic                 mem_ce_n;
    logic                 mem_oe_n;
    logic                 mem_we_n;
    logic                 mem_adv_n;

    // Controller side.
    modport slave (
        input  req, req_we, req_addr, req_len, req_wdata, mem_dq_in,
        output gnt, beat, done, rdata, mem_addr, mem_dq_out, mem_dq_oe,
        output mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n
    );

    // Requesters plus SRAM device side.
    modport master (
        output req, req_we, req_addr, req_len, req_wdata, mem_dq_in,
        input  gnt, beat, done, rdata, mem_addr, mem_dq_out, mem_dq_oe,
        input  mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n
    );
endinterface

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter; pointer remembers the last requester served.
module sram_rr_arb
    import sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);
    logic r_last;
    logic w_win;

    assign w_win = rr_pick(i_req, r_last);
    assign o_gnt = (|i_req) ? (w_win ? 2'b10 : 2'b01) : 2'b00;

    // Record the winner when the grant is taken; reset favours requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (i_update && (|i_req)) begin
            r_last <= w_win;
        end
    end
endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst sequencer for the SRAM: arbitrates two requesters, runs the
// address phase, access latency and 1..2^L_WIDTH data beats.
//
// state | meaning
// IDLE  | no grant; sample requests, latch winner's burst
// SETUP | address phase, ADV low
// WAIT  | access latency, OE low on reads
// XFER  | one beat per cycle, address counter increments
// FLUSH | read only: deliver the final registered beat
// DONE  | done pulse, grant still held
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int A_WIDTH     = DEF_A_WIDTH,
    parameter int D_WIDTH     = DEF_D_WIDTH,
    parameter int L_WIDTH     = DEF_L_WIDTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    sram_burst_ctrl_if.slave bus
);
    // Wait counter only needs to hold WAIT_CYCLES-1.
    localparam int WC_WIDTH = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_gnt;
    logic                 r_we;
    logic [A_WIDTH-1:0]   r_addr;
    logic [L_WIDTH-1:0]   r_beat_cnt;
    logic [WC_WIDTH-1:0]  r_wait_cnt;
    logic                 r_rd_beat;
    logic [D_WIDTH-1:0]   r_rdata;

    logic [1:0]           w_arb_gnt;
    logic                 w_arb_update;
    logic                 w_sel;
    logic                 w_sel_we;
    logic [A_WIDTH-1:0]   w_sel_addr;
    logic [L_WIDTH-1:0]   w_sel_len;
    logic [D_WIDTH-1:0]   w_wdata;

    logic [1:0]           w_beat;
    logic [1:0]           w_done;
    logic                 w_ce_n;
    logic                 w_oe_n;
    logic                 w_we_n;
    logic                 w_adv_n;
    logic                 w_dq_oe;
    logic [D_WIDTH-1:0]   w_dq_out;

    sram_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (bus.req),
        .i_update (w_arb_update),
        .o_gnt    (w_arb_gnt)
    );

    assign w_sel      = w_arb_gnt[1];
    assign w_sel_we   = w_sel ? bus.req_we[1] : bus.req_we[0];
    assign w_sel_addr = w_sel ? bus.req_addr[2*A_WIDTH-1:A_WIDTH] : bus.req_addr[A_WIDTH-1:0];
    assign w_sel_len  = w_sel ? bus.req_len[2*L_WIDTH-1:L_WIDTH]  : bus.req_len[L_WIDTH-1:0];
    // Write data follows the latched grant, not the live arbiter output.
    assign w_wdata    = r_gnt[1] ? bus.req_wdata[2*D_WIDTH-1:D_WIDTH] : bus.req_wdata[D_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the arbiter pointer moves only when a burst starts.
    always_comb begin
        w_state_nxt  = r_state;
        w_arb_update = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_state_nxt  = ST_SETUP;
                    w_arb_update = 1'b1;
                end
            end
            ST_SETUP: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (r_beat_cnt == '0) begin
                    w_state_nxt = r_we ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Burst context, address/beat/wait counters and the read-data pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_rd_beat  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rd_beat <= (r_state == ST_XFER) && !r_we;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_gnt      <= w_arb_gnt;
                        r_we       <= w_sel_we;
                        r_addr     <= w_sel_addr;
                        r_beat_cnt <= w_sel_len;
                    end
                end
                ST_SETUP: r_wait_cnt <= WC_WIDTH'(WAIT_CYCLES - 1);
                ST_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                ST_XFER: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_beat_cnt != '0) begin
                        r_beat_cnt <= r_beat_cnt - 1'b1;
                    end
                    if (!r_we) begin
                        r_rdata <= bus.mem_dq_in;
                    end
                end
                ST_DONE: r_gnt <= '0;
                default: ;
            endcase
        end
    end

    // Strobes and beat/done decode from state; reads report one cycle late.
    always_comb begin
        w_beat   = '0;
        w_done   = '0;
        w_ce_n   = STROBE_OFF;
        w_oe_n   = STROBE_OFF;
        w_we_n   = STROBE_OFF;
        w_adv_n  = STROBE_OFF;
        w_dq_oe  = 1'b0;
        w_dq_out = '0;
        if (r_rd_beat) begin
            w_beat = r_gnt;
        end
        case (r_state)
            ST_SETUP: begin
                w_ce_n  = STROBE_ON;
                w_adv_n = STROBE_ON;
            end
            ST_WAIT: begin
                w_ce_n = STROBE_ON;
                if (!r_we) begin
                    w_oe_n = STROBE_ON;
                end
            end
            ST_XFER: begin
                w_ce_n = STROBE_ON;
                if (r_we) begin
                    w_we_n   = STROBE_ON;
                    w_dq_oe  = 1'b1;
                    w_dq_out = w_wdata;
                    w_beat   = r_gnt;
                end else begin
                    w_oe_n = STROBE_ON;
                end
            end
            ST_DONE: w_done = r_gnt;
            default: ;
        endcase
    end

    assign bus.gnt        = r_gnt;
    assign bus.beat       = w_beat;
    assign bus.done       = w_done;
    assign bus.rdata      = r_rdata;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_dq_out = w_dq_out;
    assign bus.mem_dq_oe  = w_dq_oe;
    assign bus.mem_ce_n   = w_ce_n;
    assign bus.mem_oe_n   = w_oe_n;
    assign bus.mem_we_n   = w_we_n;
    assign bus.mem_adv_n  = w_adv_n;
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a beat scoreboard.
module tb_sram_burst_ctrl;
    localparam int AW = 23;
    localparam int DW = 16;
    localparam int LW = 4;
    localparam int WC = 2;

    typedef struct packed {
        logic [1:0]    who;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   errors = 0;
    int   done_cnt [2];
    int   wcnt [2];
    int   wexp [2];
    exp_t sb [$];

    sram_burst_ctrl_if #(.A_WIDTH(AW), .D_WIDTH(DW), .L_WIDTH(LW)) bus ();

    sram_burst_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW), .L_WIDTH(LW), .WAIT_CYCLES(WC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] wpat(input int r, input int n);
        return DW'(32'hA000 + r * 32'h0800 + n * 3);
    endfunction

    // SRAM model: read data is derived from the address while OE is low.
    assign bus.mem_dq_in = (bus.mem_oe_n == 1'b0) ? (bus.mem_addr[DW-1:0] ^ 16'h5A00) : 16'hDEAD;
    assign bus.req_wdata = {wpat(1, wcnt[1]), wpat(0, wcnt[0])};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt"},   64'(bus.gnt), 64'd0);
        chk({tag, "_beat"},  64'(bus.beat), 64'd0);
        chk({tag, "_done"},  64'(bus.done), 64'd0);
        chk({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
        chk({tag, "_addr"},  64'(bus.mem_addr), 64'd0);
        chk({tag, "_dq"},    64'({bus.mem_dq_out, bus.mem_dq_oe}), 64'd0);
        chk({tag, "_strb"},  64'({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_adv_n}), 64'hF);
    endtask

    task automatic push_burst(input int r, input bit we, input logic [AW-1:0] addr, input int len);
        exp_t e;
        for (int k = 0; k <= len; k++) begin
            e.who  = 2'(1 << r);
            e.wr   = we;
            e.addr = addr + AW'(k);
            if (we) begin
                e.data = wpat(r, wexp[r]);
                wexp[r]++;
            end else begin
                e.data = e.addr[DW-1:0] ^ 16'h5A00;
            end
            sb.push_back(e);
        end
    endtask

    task automatic drive_req(input int r, input bit we, input logic [AW-1:0] addr, input int len);
        bus.req_we[r]            = we;
        bus.req_addr[r*AW +: AW] = addr;
        bus.req_len[r*LW +: LW]  = LW'(len);
        bus.req[r]               = 1'b1;
    endtask

    // One burst from one requester, checking address phase, grant length and done.
    task automatic run_burst(input string tag, input int r, input bit we,
                             input logic [AW-1:0] addr, input int len, input int drop_at);
        int n;
        int d0;
        d0 = done_cnt[r];
        @(negedge clk);
        drive_req(r, we, addr, len);
        push_burst(r, we, addr, len);
        @(negedge clk);
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(1 << r));
        chk({tag, "_setup_addr"}, 64'(bus.mem_addr), 64'(addr));
        chk({tag, "_setup_strb"}, 64'({bus.mem_ce_n, bus.mem_adv_n}), 64'd0);
        n = 0;
        while (bus.gnt[r] && n < 100) begin
            n++;
            if (n == drop_at) bus.req[r] = 1'b0;
            @(negedge clk);
        end
        bus.req[r] = 1'b0;
        chk({tag, "_gnt_len"}, 64'(n), 64'(we ? (1 + WC + len + 1 + 1) : (1 + WC + len + 1 + 2)));
        chk({tag, "_done"}, 64'(done_cnt[r] - d0), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp_gnt);
        int n;
        n = 0;
        while (bus.gnt == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, 64'(n), 64'd1);
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(exp_gnt));
    endtask

    task automatic wait_release(input string tag, input int exp_len);
        int m;
        m = 0;
        while (bus.gnt != 2'b00 && m < 50) begin
            m++;
            @(negedge clk);
        end
        chk({tag, "_len"}, 64'(m), 64'(exp_len));
    endtask

    // Scoreboard monitor: every beat pops one expected entry.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (bus.done[i]) done_cnt[i]++;
        end
        if (bus.beat != 2'b00) begin
            if (sb.size() == 0) begin
                chk("beat_unexpected", 64'(bus.beat), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("beat_who", 64'(bus.beat), 64'(e.who));
                if (e.wr) begin
                    chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
                    chk("wr_data", 64'(bus.mem_dq_out), 64'(e.data));
                    chk("wr_strb", 64'({bus.mem_we_n, bus.mem_dq_oe, bus.mem_ce_n, bus.mem_oe_n}), 64'b0101);
                    wcnt[e.who[1]]++;
                end else begin
                    chk("rd_data", 64'(bus.rdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int d1;
        done_cnt = '{0, 0};
        wcnt     = '{0, 0};
        wexp     = '{0, 0};
        bus.req      = 2'b00;
        bus.req_we   = 2'b00;
        bus.req_addr = '0;
        bus.req_len  = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        // Both requesting continuously: 0 wins first tie, then alternate.
        @(negedge clk);
        drive_req(0, 1'b1, 23'h000200, 0);
        drive_req(1, 1'b1, 23'h000300, 0);
        push_burst(0, 1'b1, 23'h000200, 0);
        push_burst(1, 1'b1, 23'h000300, 0);
        push_burst(0, 1'b1, 23'h000200, 0);
        push_burst(1, 1'b1, 23'h000300, 0);
        for (int g = 0; g < 4; g++) begin
            wait_grant("arb", (g % 2 == 0) ? 2'b01 : 2'b10);
            if (g == 3) bus.req = 2'b00;
            wait_release("arb", 5);
        end
        chk("arb_done0", 64'(done_cnt[0]), 64'd2);
        chk("arb_done1", 64'(done_cnt[1]), 64'd2);
        chk("arb_sb_empty", 64'(sb.size()), 64'd0);

        // Lone requester gets consecutive grants.
        @(negedge clk);
        drive_req(1, 1'b1, 23'h000400, 0);
        push_burst(1, 1'b1, 23'h000400, 0);
        push_burst(1, 1'b1, 23'h000400, 0);
        for (int g = 0; g < 2; g++) begin
            wait_grant("solo", 2'b10);
            if (g == 1) bus.req = 2'b00;
            wait_release("solo", 5);
        end
        chk("solo_sb_empty", 64'(sb.size()), 64'd0);

        run_burst("wr_single", 0, 1'b1, 23'h000010, 0, 1);
        run_burst("rd_burst", 1, 1'b0, 23'h000100, 3, 1);
        run_burst("wrap", 0, 1'b1, 23'h7FFFFE, 3, 1);
        run_burst("rd_max", 0, 1'b0, 23'h002000, 15, 1);
        run_burst("drop", 0, 1'b1, 23'h000040, 7, 6);

        // Reset in the middle of XFER: immediate return to reset values, no done.
        d1 = done_cnt[1];
        @(negedge clk);
        drive_req(1, 1'b1, 23'h000500, 7);
        push_burst(1, 1'b1, 23'h000500, 7);
        n = 0;
        while (!bus.beat[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_beat_seen", 64'(bus.beat[1]), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        bus.req = 2'b00;
        #1;
        check_reset("rst_mid");
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", 64'(done_cnt[1] - d1), 64'd0);
        sb.delete();
        wexp[1] = wcnt[1];
        rst = 1'b1;

        // Pointer is back to its reset value: requester 0 wins the tie again.
        @(negedge clk);
        drive_req(0, 1'b1, 23'h000600, 0);
        drive_req(1, 1'b1, 23'h000700, 0);
        push_burst(0, 1'b1, 23'h000600, 0);
        wait_grant("post_rst", 2'b01);
        bus.req = 2'b00;
        wait_release("post_rst", 5);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Burst sequencer and two-requester arbiter for the Micron SRAM. Grants one requester at a time, drives the SRAM control strobes, and runs a linear address counter for bursts of 1–16 beats. Returns per-beat strobes and read data to the granted requester. Sits between the bus-side masters (CPU port, DMA/video port) and the SRAM pins.

## Interface
Parameters:
- A_WIDTH, 23, SRAM word-address width.
- D_WIDTH, 16, SRAM data width.
- L_WIDTH, 4, burst-length field width; beats = len + 1.
- WAIT_CYCLES, 2, access-latency cycles between address phase and first beat (≥1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  2  per-requester request, level; bit i = requester i.
- req_we  in  2  1 = write burst, 0 = read burst.
- req_addr  in  2*A_WIDTH  start word address; requester i in slice i.
- req_len  in  2*L_WIDTH  beats minus one.
- req_wdata  in  2*D_WIDTH  write data for current beat.
- gnt  out  2  one-hot grant, held for whole burst.
- beat  out  2  one-hot beat strobe to granted requester.
- done  out  2  one-cycle pulse after last beat.
- rdata  out  D_WIDTH  read data, valid when beat is high on a read.
- mem_addr  out  A_WIDTH  SRAM address.
- mem_dq_out  out  D_WIDTH  SRAM write data.
- mem_dq_oe  out  1  1 = drive DQ.
- mem_dq_in  in  D_WIDTH  SRAM read data.
- mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n  out  1 each  SRAM strobes, active-low.

## Operation
- FSM states: IDLE, SETUP, WAIT, XFER, FLUSH, DONE.
- IDLE: if any req, select winner, latch its we/addr/len, load address counter with addr, set gnt → SETUP.
- SETUP (1 cycle): mem_ce_n=0, mem_adv_n=0, mem_addr=start address → WAIT.
- WAIT (WAIT_CYCLES cycles): mem_ce_n=0; on read mem_oe_n=0 → XFER.
- XFER (len+1 cycles, one beat per cycle): address counter increments each cycle.
  - Write: mem_we_n=0, mem_dq_oe=1, mem_dq_out=req_wdata of granted requester; beat asserted in the same cycle.
  - Read: mem_oe_n=0; mem_dq_in registered at end of each XFER cycle; beat and rdata asserted the following cycle.
  - After last beat: read → FLUSH, write → DONE.
- FLUSH (read only, 1 cycle): delivers final read beat; mem_ce_n=1.
- DONE (1 cycle): done pulse, gnt still high, all strobes inactive → IDLE; gnt drops on IDLE entry.
- Arbitration: round-robin. Both requesting → grant the requester not served last. Last-served pointer resets to 1, so requester 0 wins the first tie.
- Requests are sampled only in IDLE. Deassertion of req mid-burst is ignored; burst runs to completion.
- Address arithmetic: counter is A_WIDTH bits, wraps from 2^A_WIDTH−1 to 0 with no error.
- req_len = 0 gives a single-beat burst; req_len = 2^L_WIDTH−1 gives 16 beats.

## Timing
- Reset (rst=0, async): state IDLE; gnt=0, beat=0, done=0, rdata=0, mem_addr=0, mem_dq_out=0, mem_dq_oe=0, all mem_*_n=1; round-robin pointer=1. Reset mid-burst aborts immediately with no done pulse.
- req high in IDLE at edge N: gnt high from N+1, SETUP occupies N+1.
- Write burst of B beats: gnt high for 1+WAIT_CYCLES+B+1 cycles.
- Read burst of B beats: gnt high for 1+WAIT_CYCLES+B+2 cycles.
- Write data: requester presents beat k data while beat is high; beat k+1 data is due the cycle after.
- Back-to-back: one IDLE cycle minimum between bursts.

## Structure
- Shared package sram_pkg: FSM state enum, strobe-inactive constants, default A_WIDTH/D_WIDTH.
- Sub-module sram_rr_arb: 2-way round-robin arbiter (req, update strobe → one-hot grant, pointer register, async active-low reset).
- Address counter and beat counter are inline registers in the top.

## Test plan
- Reset: hold rst=0 mid-XFER → all outputs return to reset values the same cycle; no done pulse.
- Single write: req[0], we=1, addr=0x000010, len=0, WAIT_CYCLES=2 → gnt[0] for 5 cycles; one beat with mem_we_n=0 at mem_addr 0x000010.
- Read burst: req[1], we=0, addr=0x000100, len=3; SRAM model returns addr-derived data → beat[1] 4 cycles with rdata matching 0x100–0x103; done[1] pulses once.
- Address wrap: addr=0x7FFFFE, len=3 → mem_addr sequence 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
- Arbitration: both req held continuously → grants alternate 0, 1, 0, 1; a single requester gets consecutive grants.
- Mid-burst drop: req[0] deasserted during XFER of a len=7 write → all 8 beats still issued; done[0] pulses.
